hf_tag_manchester_tx: RTL and testbench

// - ISO14443-A tag-side transmitter (tag -> reader): turns ARM-supplied bytes into fc/16 subcarrier

---
 rtl/hf_tag_manchester_tx.sv | 152 +++++++++++++++
 tb/tb_hf_tag_manchester_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hf_tag_manchester_tx.sv
`default_nettype none
// ============================================================================
// Module   : hf_tag_manchester_tx
// Purpose  : ISO14443-A tag->reader transmitter, byte FIFO to Manchester-coded
//            fc/16 subcarrier load modulation. Option macro: TAGSIM_PARITY_EN
// Revision : 1.0 - initial release
// ============================================================================
module hf_tag_manchester_tx #(
  parameter int SUB_DIV    = 16,
  parameter int BIT_LEN    = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       mod_out,
  output logic       busy,
  output logic       underrun
);
  localparam int c_CNT_W = $clog2(BIT_LEN);
  localparam int c_AW    = $clog2(FIFO_DEPTH);

  localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(BIT_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_BIT = c_CNT_W'(BIT_LEN / 2);
  localparam logic [c_CNT_W-1:0] c_SUB      = c_CNT_W'(SUB_DIV);
  localparam logic [c_CNT_W-1:0] c_HALF_SUB = c_CNT_W'(SUB_DIV / 2);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_AW:0]      c_PTR_ONE  = (c_AW+1)'(1);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_SOF  = 3'd1;
  localparam logic [2:0] c_ST_DATA = 3'd2;
  localparam logic [2:0] c_ST_PAR  = 3'd3;
  localparam logic [2:0] c_ST_EOF  = 3'd4;

  logic [c_CNT_W-1:0] r_carrier_cnt;
  logic [8:0]         r_mem [FIFO_DEPTH];
  logic [c_AW:0]      r_wptr, r_rptr;
  logic [2:0]         r_state, w_state_next, w_after_byte;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_idx;
  logic               r_par, r_last, r_mod_out;
  logic               w_tick, w_empty, w_full, w_push, w_pop, w_byte_end;
  logic               w_bit_val, w_active, w_first_half, w_sub_high;
  logic [8:0]         w_head;

  assign w_tick       = (r_carrier_cnt == c_BIT_LAST);
  assign w_first_half = (r_carrier_cnt < c_HALF_BIT);
  assign w_sub_high   = ((r_carrier_cnt % c_SUB) < c_HALF_SUB);

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset)       r_carrier_cnt <= '0;
    else if (w_tick) r_carrier_cnt <= '0;
    else             r_carrier_cnt <= r_carrier_cnt + c_CNT_ONE;
  end

  // FIFO entries hold {tx_last, tx_data}; ready derives from pointers only
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                    (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign tx_ready = !w_full;
  assign w_push   = tx_valid && !w_full;
  assign w_head   = r_mem[r_rptr[c_AW-1:0]];

  always_ff @(posedge ck_1356meg) begin
    if (w_push) r_mem[r_wptr[c_AW-1:0]] <= {tx_last, tx_data};
  end

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
    end
  end

`ifdef TAGSIM_PARITY_EN
  assign w_byte_end = (r_state == c_ST_PAR);
`else
  assign w_byte_end = (r_state == c_ST_DATA) && (r_bit_idx == 3'd7);
`endif

  assign w_after_byte = (r_last || w_empty) ? c_ST_EOF : c_ST_DATA;
  assign w_pop = w_tick && ((r_state == c_ST_SOF) ||
                            (w_byte_end && !r_last && !w_empty));

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset)       r_state <= c_ST_IDLE;
    else if (w_tick) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: if (!w_empty) w_state_next = c_ST_SOF;
      c_ST_SOF:  w_state_next = c_ST_DATA;
      c_ST_DATA: begin
        if (w_byte_end)               w_state_next = w_after_byte;
        else if (r_bit_idx == 3'd7)   w_state_next = c_ST_PAR;
      end
      c_ST_PAR:  w_state_next = w_after_byte;
      c_ST_EOF:  w_state_next = w_empty ? c_ST_IDLE : c_ST_SOF;
      default:   w_state_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != c_ST_IDLE);
    underrun  = w_tick && w_byte_end && !r_last && w_empty;
    w_bit_val = 1'b0;
    w_active  = 1'b0;
    case (r_state)
      c_ST_SOF:  begin w_bit_val = 1'b1;       w_active = 1'b1; end
      c_ST_DATA: begin w_bit_val = r_shift[0]; w_active = 1'b1; end
      c_ST_PAR:  begin w_bit_val = r_par;      w_active = 1'b1; end
      default:   ;
    endcase
  end

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_par     <= 1'b0;
      r_last    <= 1'b0;
    end else if (w_pop) begin
      r_shift   <= w_head[7:0];
      r_last    <= w_head[8];
      r_par     <= ~^w_head[7:0];
      r_bit_idx <= '0;
    end else if (w_tick && (r_state == c_ST_DATA)) begin
      r_shift   <= {1'b0, r_shift[7:1]};
      r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  // Logic 1 modulates the first half-bit, logic 0 the second
  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) r_mod_out <= 1'b0;
    else       r_mod_out <= w_active && w_sub_high &&
                            (w_bit_val ? w_first_half : !w_first_half);
  end

  assign mod_out = r_mod_out;

endmodule
`default_nettype wire

// File: tb/tb_hf_tag_manchester_tx.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench for hf_tag_manchester_tx: per-bit-period mod_out patterns, busy
// length, underrun, FIFO full and asynchronous reset.
module tb_hf_tag_manchester_tx;
`ifdef TAGSIM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       ck_1356meg = 1'b0;
  logic       reset      = 1'b1;
  logic [7:0] tx_data    = 8'h00;
  logic       tx_last    = 1'b0;
  logic       tx_valid   = 1'b0;
  logic       tx_ready, mod_out, busy, underrun;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] fb[$];
  logic       f_last;

  hf_tag_manchester_tx dut (
    .ck_1356meg(ck_1356meg), .reset(reset), .tx_data(tx_data),
    .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mod_out(mod_out), .busy(busy), .underrun(underrun)
  );

  always #5 ck_1356meg = ~ck_1356meg;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // kind: 1 = logic 1, 0 = logic 0, 2 = unmodulated (EOF)
  function automatic logic [127:0] exp_pat(input int kind);
    logic [127:0] p;
    logic         sub;
    p = '0;
    for (int j = 0; j < 128; j++) begin
      sub = ((j % 16) < 8);
      if (kind == 1)      p[j] = (j < 64) && sub;
      else if (kind == 0) p[j] = (j >= 64) && sub;
    end
    return p;
  endfunction

  task automatic push(input logic [7:0] d, input logic l);
    int w;
    w = 0;
    @(negedge ck_1356meg);
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    while (!tx_ready && w < 1000) begin @(negedge ck_1356meg); w++; end
    chk("push_ready", tx_ready, 1'b1);
    @(posedge ck_1356meg);
    #1 tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic run_frame(input string name);
    int           bits[$];
    int           nb, t, bcnt, ucnt, upos;
    bit           seen;
    logic [127:0] rec [64];
    bits.push_back(1);
    foreach (fb[i]) begin
      for (int k = 0; k < 8; k++) bits.push_back(int'(fb[i][k]));
      if (PAR) bits.push_back(int'(~^fb[i]));
    end
    bits.push_back(2);
    nb = bits.size();
    fork
      begin
        seen = 1'b0;
        t = 0;
        while (!seen && t < 2000) begin
          @(negedge ck_1356meg);
          if (busy) seen = 1'b1;
          t++;
        end
        chk({name, "_start"}, seen, 1'b1);
        if (seen) begin
          bcnt = 0; ucnt = 0; upos = -1;
          for (int c = 0; c <= nb*128 + 16; c++) begin
            if (c > 0) @(negedge ck_1356meg);
            if (busy) bcnt++;
            if (underrun) begin ucnt++; upos = c; end
            if (c >= 1 && c <= nb*128) rec[(c-1)/128][(c-1)%128] = mod_out;
          end
          for (int i = 0; i < nb; i++)
            chk($sformatf("%s_bit%0d", name, i), rec[i], exp_pat(bits[i]));
          chk({name, "_busy_len"}, bcnt, nb*128);
          chk({name, "_underrun_cnt"}, ucnt, f_last ? 0 : 1);
          if (!f_last) chk({name, "_underrun_pos"}, upos, (nb-2)*128 + 127);
        end
      end
      begin
        foreach (fb[i]) push(fb[i], f_last && (i == fb.size() - 1));
        if (fb.size() == 4) begin
          @(negedge ck_1356meg);
          chk({name, "_full_ready"}, tx_ready, 1'b0);
        end
      end
    join
    repeat (20) @(negedge ck_1356meg);
  endtask

  initial begin
    int w, act;
    #23;
    chk("rst_mod", mod_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_underrun", underrun, 1'b0);
    @(negedge ck_1356meg);
    reset = 1'b0;
    repeat (37) @(negedge ck_1356meg);

    fb = '{8'h01};               f_last = 1'b1; run_frame("b01");
    fb = '{8'h00};               f_last = 1'b1; run_frame("b00");
    fb = '{8'hA5, 8'h3C};        f_last = 1'b1; run_frame("a5_3c");
    fb = '{8'h55};               f_last = 1'b0; run_frame("b55_nolast");
    fb = '{8'h11, 8'h22, 8'h33, 8'h44}; f_last = 1'b1; run_frame("four");

    // Reset mid-frame while a second frame waits in the FIFO
    push(8'h01, 1'b1);
    push(8'hFF, 1'b1);
    w = 0;
    while (!(busy && mod_out) && w < 2000) begin @(negedge ck_1356meg); w++; end
    chk("mid_mod_high", mod_out, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_mod", mod_out, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", tx_ready, 1'b1);
    @(negedge ck_1356meg);
    #2 reset = 1'b0;
    act = 0;
    repeat (400) begin
      @(negedge ck_1356meg);
      if (busy || mod_out) act++;
    end
    chk("post_rst_idle", act, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
